// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin pick function for the Wishbone arbiter.
// Pure declarations; no state, no latency.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Sized for the largest supported configuration so the package stays parameter-free.
    localparam int MAX_MASTERS = 8;
    localparam int OWNER_W     = $clog2(MAX_MASTERS);

    // First requester found scanning upward from last+1, wrapping at n.
    function automatic logic [OWNER_W-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [OWNER_W-1:0]     last,
        input int                     n
    );
        logic [OWNER_W-1:0] win;
        logic               found;
        int                 idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            idx = int'(last) + k;
            if (idx >= n) idx = idx - n;
            if (!found && (k <= n) && req[idx[OWNER_W-1:0]]) begin
                win   = idx[OWNER_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundles the master-side and slave-side Wishbone signals of the arbiter.
// slave modport is the arbiter's view; master modport is the surrounding agents' view.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 4
);
    logic [NUM_MASTERS-1:0]        m_cyc_i;
    logic [NUM_MASTERS-1:0]        m_stb_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS-1:0]        m_lock_i;
    logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_dat_i;
    logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i;
    logic [DATA_W-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [NUM_MASTERS-1:0]        m_err_o;
    logic [NUM_MASTERS-1:0]        m_rty_o;

    logic                          s_cyc_o;
    logic                          s_stb_o;
    logic                          s_we_o;
    logic                          s_lock_o;
    logic [ADDR_W-1:0]             s_adr_o;
    logic [DATA_W-1:0]             s_dat_o;
    logic [SEL_W-1:0]              s_sel_o;
    logic                          s_ack_i;
    logic                          s_err_i;
    logic                          s_rty_i;
    logic [DATA_W-1:0]             s_dat_i;

    logic [NUM_MASTERS-1:0]        grant_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_dat_i, m_sel_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
        output grant_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_err_i, s_rty_i, s_dat_i,
        input  grant_o
    );

endinterface

// File: rtl/wb_arb_wdog.sv
// Per-transfer watchdog: counts unterminated STB cycles, pulses timeout_o when the count hits TIMEOUT.
// Combinational pulse in the same cycle; a slave termination in that cycle suppresses it.
module wb_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stb_i,
    input  logic term_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;

    assign timeout_o = stb_i && !term_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear_i || !stb_i || term_i || timeout_o) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: registered grant, LOCK hold-over, watchdog-forced ERR.
// Grant one cycle after CYC; one idle cycle between owners; no buffering, slave stalls pass straight through.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rst,
    wb_rr_arbiter_if.slave  bus
);

    arb_state_e             state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     last_q,  last_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    logic [MAX_MASTERS-1:0] req_pad;
    logic [OWNER_W-1:0]     win;
    logic                   own_cyc, own_stb, own_we, own_lock;
    logic [ADDR_W-1:0]      own_adr;
    logic [DATA_W-1:0]      own_dat;
    logic [SEL_W-1:0]       own_sel;
    logic                   raw_stb, stb_live, term, wdog_to;

    assign req_pad = MAX_MASTERS'(bus.m_cyc_i);
    assign win     = rr_pick(req_pad, last_q, NUM_MASTERS);

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        own_adr  = '0;
        own_dat  = '0;
        own_sel  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (state_q == OWN && owner_q == OWNER_W'(i)) begin
                own_cyc  = bus.m_cyc_i[i];
                own_stb  = bus.m_stb_i[i];
                own_we   = bus.m_we_i[i];
                own_lock = bus.m_lock_i[i];
                own_adr  = bus.m_adr_i[i*ADDR_W +: ADDR_W];
                own_dat  = bus.m_dat_i[i*DATA_W +: DATA_W];
                own_sel  = bus.m_sel_i[i*SEL_W +: SEL_W];
            end
        end
    end

    assign raw_stb  = own_stb & own_cyc;
    assign term     = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    assign stb_live = raw_stb & ~wdog_to;

    wb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .stb_i     (raw_stb),
        .term_i    (term),
        .clear_i   (state_q != OWN),
        .timeout_o (wdog_to)
    );

    // A timed-out cycle is withdrawn from the slave for that one cycle.
    assign bus.s_cyc_o  = own_cyc & ~wdog_to;
    assign bus.s_stb_o  = stb_live;
    assign bus.s_we_o   = own_we;
    assign bus.s_lock_o = own_lock;
    assign bus.s_adr_o  = own_adr;
    assign bus.s_dat_o  = own_dat;
    assign bus.s_sel_o  = own_sel;

    assign bus.m_dat_o  = bus.s_dat_i;
    assign bus.m_ack_o  = grant_q & {NUM_MASTERS{bus.s_ack_i & stb_live}};
    assign bus.m_err_o  = grant_q & {NUM_MASTERS{(bus.s_err_i & stb_live) | wdog_to}};
    assign bus.m_rty_o  = grant_q & {NUM_MASTERS{bus.s_rty_i & stb_live}};
    assign bus.grant_o  = grant_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = OWN;
                    owner_d = win;
                    last_d  = win;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        grant_d[i] = (win == OWNER_W'(i));
                    end
                end
            end
            OWN: begin
                // LOCK alone keeps ownership so a locked sequence cannot be split.
                if (!(own_cyc || own_lock)) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWNER_W'(NUM_MASTERS - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: single transfer, contention order, wrap, lock, watchdog, reset.
// Four masters, TIMEOUT of 8; the slave side is driven by hand cycle by cycle.
module tb_wb_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    wb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SEL_W       (SW),
        .TIMEOUT     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0({bus.s_ack_i, bus.s_err_i, bus.s_rty_i}))
                else $error("multiple slave terminations in one cycle");
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic on);
        logic [NM-1:0] bit_m;
        bit_m = NM'(1 << m);
        if (on) begin
            bus.m_cyc_i = bus.m_cyc_i | bit_m;
            bus.m_stb_i = bus.m_stb_i | bit_m;
        end else begin
            bus.m_cyc_i = bus.m_cyc_i & ~bit_m;
            bus.m_stb_i = bus.m_stb_i & ~bit_m;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0; bus.m_lock_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0; bus.s_dat_i = '0;
        repeat (2) step();

        chk_eq("rst_grant", 32'(bus.grant_o), 32'h0);
        chk_eq("rst_s_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk_eq("rst_s_stb", 32'(bus.s_stb_o), 32'h0);
        chk_eq("rst_s_lock", 32'(bus.s_lock_o), 32'h0);
        chk_eq("rst_s_adr", bus.s_adr_o, 32'h0);
        chk_eq("rst_m_ack", 32'(bus.m_ack_o), 32'h0);
        chk_eq("rst_m_err", 32'(bus.m_err_o), 32'h0);

        // Single master write, slave acks on the third STB cycle.
        rst = 1'b0;
        bus.m_cyc_i = 4'b0001; bus.m_stb_i = 4'b0001; bus.m_we_i = 4'b0001;
        bus.m_adr_i[0 +: AW] = 32'h100;
        bus.m_sel_i[0 +: SW] = 4'hf;
        #1;
        chk_eq("t1_pre_grant", 32'(bus.grant_o), 32'h0);
        step();
        chk_eq("t1_grant", 32'(bus.grant_o), 32'h1);
        chk_eq("t1_s_cyc", 32'(bus.s_cyc_o), 32'h1);
        chk_eq("t1_s_adr", bus.s_adr_o, 32'h100);
        chk_eq("t1_s_we", 32'(bus.s_we_o), 32'h1);
        chk_eq("t1_s_sel", 32'(bus.s_sel_o), 32'hf);
        step();
        chk_eq("t1_no_ack_yet", 32'(bus.m_ack_o), 32'h0);
        step();
        bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hdeadbeef;
        #1;
        chk_eq("t1_ack", 32'(bus.m_ack_o), 32'h1);
        chk_eq("t1_dat", bus.m_dat_o, 32'hdeadbeef);
        step();
        bus.s_ack_i = 1'b0; bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        #1;
        chk_eq("t1_ack_gone", 32'(bus.m_ack_o), 32'h0);
        chk_eq("t1_grant_hold", 32'(bus.grant_o), 32'h1);
        step();
        chk_eq("t1_grant_drop", 32'(bus.grant_o), 32'h0);

        // Contention from reset: order 0,1,2,3,0 with an idle cycle between owners.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int m = 0; m < NM; m++) bus.m_adr_i[m*AW +: AW] = 32'h1000 + 32'(m);
        bus.m_cyc_i = 4'b1111; bus.m_stb_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % NM;
            step();
            chk_eq($sformatf("rr_grant_%0d", k), 32'(bus.grant_o), 32'(1 << e));
            chk_eq($sformatf("rr_adr_%0d", k), bus.s_adr_o, 32'h1000 + 32'(e));
            if (k == 1) begin
                bus.s_rty_i = 1'b1;
                #1;
                chk_eq("rr_rty_route", 32'(bus.m_rty_o), 32'(1 << e));
            end else begin
                bus.s_ack_i = 1'b1;
                #1;
                chk_eq($sformatf("rr_ack_%0d", k), 32'(bus.m_ack_o), 32'(1 << e));
            end
            step();
            bus.s_ack_i = 1'b0; bus.s_rty_i = 1'b0;
            set_req(e, 1'b0);
            step();
            chk_eq($sformatf("rr_idle_%0d", k), 32'(bus.grant_o), 32'h0);
            set_req(e, 1'b1);
        end
        bus.m_cyc_i = '0; bus.m_stb_i = '0;
        step();

        // Wrap: make master 2 the last winner, then 0011 picks 0, then 1.
        bus.m_cyc_i = 4'b0100; bus.m_stb_i = 4'b0100;
        step();
        chk_eq("wrap_g2", 32'(bus.grant_o), 32'h4);
        bus.m_cyc_i = '0; bus.m_stb_i = '0;
        step();
        bus.m_cyc_i = 4'b0011; bus.m_stb_i = 4'b0011;
        step();
        chk_eq("wrap_g0", 32'(bus.grant_o), 32'h1);
        // Owner abandons mid-STB; a late ack must not reach anyone.
        bus.m_cyc_i = 4'b0010; bus.m_stb_i = 4'b0010; bus.s_ack_i = 1'b1;
        #1;
        chk_eq("abandon_no_ack", 32'(bus.m_ack_o), 32'h0);
        step();
        bus.s_ack_i = 1'b0;
        chk_eq("wrap_idle", 32'(bus.grant_o), 32'h0);
        bus.m_cyc_i = 4'b0011; bus.m_stb_i = 4'b0011;
        step();
        chk_eq("wrap_g1", 32'(bus.grant_o), 32'h2);
        bus.m_cyc_i = '0; bus.m_stb_i = '0;
        step();

        // Lock hold-over: master 1 keeps LOCK with CYC low while master 0 waits.
        bus.m_cyc_i = 4'b0010; bus.m_lock_i = 4'b0010;
        step();
        chk_eq("lock_g1", 32'(bus.grant_o), 32'h2);
        bus.m_cyc_i = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_eq($sformatf("lock_hold_%0d", c), 32'(bus.grant_o), 32'h2);
            chk_eq($sformatf("lock_s_lock_%0d", c), 32'(bus.s_lock_o), 32'h1);
            chk_eq($sformatf("lock_s_cyc_%0d", c), 32'(bus.s_cyc_o), 32'h0);
        end
        bus.m_lock_i = '0;
        step();
        chk_eq("lock_release_idle", 32'(bus.grant_o), 32'h0);
        step();
        chk_eq("lock_g0", 32'(bus.grant_o), 32'h1);
        bus.m_cyc_i = '0;
        step();

        // Watchdog: forced ERR on the 9th unterminated STB cycle, slave ack wins on the next round.
        bus.m_cyc_i = 4'b0010; bus.m_stb_i = 4'b0010;
        step();
        chk_eq("wd_grant", 32'(bus.grant_o), 32'h2);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_eq($sformatf("wd_no_err_c%0d", c), 32'(bus.m_err_o), 32'h0);
        end
        step();
        chk_eq("wd_err", 32'(bus.m_err_o), 32'h2);
        chk_eq("wd_stb_forced", 32'(bus.s_stb_o), 32'h0);
        chk_eq("wd_cyc_forced", 32'(bus.s_cyc_o), 32'h0);
        step();
        chk_eq("wd_err_once", 32'(bus.m_err_o), 32'h0);
        chk_eq("wd_stb_back", 32'(bus.s_stb_o), 32'h1);
        repeat (8) step();
        bus.s_ack_i = 1'b1;
        #1;
        chk_eq("wd_ack_wins_ack", 32'(bus.m_ack_o), 32'h2);
        chk_eq("wd_ack_wins_err", 32'(bus.m_err_o), 32'h0);
        chk_eq("wd_ack_wins_stb", 32'(bus.s_stb_o), 32'h1);
        step();
        bus.s_ack_i = 1'b0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
        step();

        // Reset in the middle of an owned transfer.
        bus.m_cyc_i = 4'b0100; bus.m_stb_i = 4'b0100;
        step();
        chk_eq("mid_rst_grant_pre", 32'(bus.grant_o), 32'h4);
        chk_eq("mid_rst_stb_pre", 32'(bus.s_stb_o), 32'h1);
        rst = 1'b1;
        bus.m_cyc_i = 4'b0101; bus.m_stb_i = 4'b0101;
        step();
        chk_eq("mid_rst_grant", 32'(bus.grant_o), 32'h0);
        chk_eq("mid_rst_s_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk_eq("mid_rst_s_stb", 32'(bus.s_stb_o), 32'h0);
        rst = 1'b0;
        step();
        chk_eq("post_rst_g0", 32'(bus.grant_o), 32'h1);
        chk_eq("post_rst_stb", 32'(bus.s_stb_o), 32'h1);
        bus.m_cyc_i = '0; bus.m_stb_i = '0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
